// File: rtl/vector_writeback_arbiter.sv
// vector_writeback_arbiter
//   Final writeback stage in front of the vector register file write port. It merges
//   execute results (no backpressure, normally highest priority) with memory load
//   returns (valid/ready, buffered in a small in-order FIFO). At most one masked write
//   is issued per cycle, and that write is registered. A starvation counter raises
//   wb_ex_stall so that a load waiting in the FIFO is guaranteed to drain.
//
// Ports
//   clk, reset                   clock; synchronous active-high reset
//   ex_valid/ex_reg/ex_value/ex_mask       execute result, no backpressure
//   mem_valid/mem_ready/mem_reg/mem_value/mem_mask  load return handshake
//   wb_ex_stall                  upstream must hold ex_valid low while this is set
//   fifo_count                   occupied load FIFO entries
//   wb_writeback_reg/value/mask  register file write data (held when idle)
//   wb_enable_vector_writeback   register file write strobe

`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef VECTOR_BITS
`define VECTOR_BITS 128
`endif
`ifndef VECTOR_LANES
`define VECTOR_LANES 16
`endif

module vector_writeback_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             ex_valid,
   input  logic [`REG_IDX_WIDTH-1:0]        ex_reg,
   input  logic [`VECTOR_BITS-1:0]          ex_value,
   input  logic [`VECTOR_LANES-1:0]         ex_mask,
   input  logic                             mem_valid,
   output logic                             mem_ready,
   input  logic [`REG_IDX_WIDTH-1:0]        mem_reg,
   input  logic [`VECTOR_BITS-1:0]          mem_value,
   input  logic [`VECTOR_LANES-1:0]         mem_mask,
   output logic                             wb_ex_stall,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
   output logic [`REG_IDX_WIDTH-1:0]        wb_writeback_reg,
   output logic [`VECTOR_BITS-1:0]          wb_writeback_value,
   output logic [`VECTOR_LANES-1:0]         wb_writeback_mask,
   output logic                             wb_enable_vector_writeback
);

   localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic [`REG_IDX_WIDTH-1:0] dst;
      logic [`VECTOR_LANES-1:0]  mask;
      logic [`VECTOR_BITS-1:0]   value;
   } wb_entry_t;

   typedef enum logic [1:0] {SelNone, SelEx, SelFifo, SelMem} sel_e;

   // State
   wb_entry_t                 fifo_mem [FIFO_DEPTH];
   logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]           count_q, count_d;
   logic [StarveW-1:0]        starve_q, starve_d;
   logic                      stall_q, stall_d;
   wb_entry_t                 wb_q, wb_d;
   logic                      wb_en_q, wb_en_d;

   // Decode
   logic      fifo_empty, fifo_full, mem_accept, ex_ok, push, pop;
   sel_e      sel;
   wb_entry_t head, mem_entry, ex_entry;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
   // Ready never looks at this cycle's pop, so a full FIFO refuses even while draining.
   assign mem_ready  = !reset && !fifo_full;
   assign mem_accept = mem_valid && mem_ready;
   // An execute result presented during a stall is a protocol violation and is dropped.
   assign ex_ok      = ex_valid && !stall_q;

   assign head      = fifo_mem[rd_ptr_q];
   assign mem_entry = '{dst: mem_reg, mask: mem_mask, value: mem_value};
   assign ex_entry  = '{dst: ex_reg, mask: ex_mask, value: ex_value};

   always_comb begin
      sel = SelNone;
      if (stall_q && !fifo_empty) begin
         sel = SelFifo;
      end else if (ex_ok) begin
         sel = SelEx;
      end else if (!fifo_empty) begin
         sel = SelFifo;
      end else if (mem_accept) begin
         sel = SelMem;  // fall-through, never occupies a FIFO slot
      end
   end

   assign pop  = (sel == SelFifo);
   assign push = mem_accept && (sel != SelMem);

   // FIFO bookkeeping; pointers wrap naturally at the power-of-two depth.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end
   end

   // Starvation: counts cycles a waiting load loses to execute; any pop or empty clears it.
   always_comb begin
      starve_d = '0;
      if (!fifo_empty && (sel == SelEx)) begin
         if (starve_q == StarveW'(STARVE_LIMIT)) begin
            starve_d = starve_q;
         end else begin
            starve_d = starve_q + StarveW'(1);
         end
      end
      stall_d = (starve_d == StarveW'(STARVE_LIMIT));
   end

   // Writeback output; data holds its previous value when nothing is issued.
   always_comb begin
      wb_d    = wb_q;
      wb_en_d = 1'b0;
      case (sel)
         SelEx: begin
            wb_d    = ex_entry;
            wb_en_d = 1'b1;
         end
         SelFifo: begin
            wb_d    = head;
            wb_en_d = 1'b1;
         end
         SelMem: begin
            wb_d    = mem_entry;
            wb_en_d = 1'b1;
         end
         default: begin
            wb_d    = wb_q;
            wb_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
         wb_q     <= '0;
         wb_en_q  <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         stall_q  <= stall_d;
         wb_q     <= wb_d;
         wb_en_q  <= wb_en_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= mem_entry;
      end
   end

   assign wb_ex_stall                = stall_q;
   assign fifo_count                 = count_q;
   assign wb_writeback_reg           = wb_q.dst;
   assign wb_writeback_value         = wb_q.value;
   assign wb_writeback_mask          = wb_q.mask;
   assign wb_enable_vector_writeback = wb_en_q;

`ifndef SYNTHESIS
   ex_during_stall: assert property (@(posedge clk) disable iff (reset) !(stall_q && ex_valid))
      else $error("ex_valid high while wb_ex_stall set; execute result dropped");
`endif

endmodule

// File: tb/tb_vector_writeback_arbiter.sv
// Directed bench for vector_writeback_arbiter: reset, execute issue, fall-through,
// FIFO fill/backpressure, starvation stall and drain, push+pop, reset mid-traffic.

`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef VECTOR_BITS
`define VECTOR_BITS 128
`endif
`ifndef VECTOR_LANES
`define VECTOR_LANES 16
`endif

module tb_vector_writeback_arbiter;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        ex_valid;
   logic [`REG_IDX_WIDTH-1:0]   ex_reg;
   logic [`VECTOR_BITS-1:0]     ex_value;
   logic [`VECTOR_LANES-1:0]    ex_mask;
   logic                        mem_valid;
   logic                        mem_ready;
   logic [`REG_IDX_WIDTH-1:0]   mem_reg;
   logic [`VECTOR_BITS-1:0]     mem_value;
   logic [`VECTOR_LANES-1:0]    mem_mask;
   logic                        wb_ex_stall;
   logic [2:0]                  fifo_count;
   logic [`REG_IDX_WIDTH-1:0]   wb_writeback_reg;
   logic [`VECTOR_BITS-1:0]     wb_writeback_value;
   logic [`VECTOR_LANES-1:0]    wb_writeback_mask;
   logic                        wb_enable_vector_writeback;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vector_writeback_arbiter #(
      .FIFO_DEPTH   (4),
      .STARVE_LIMIT (8)
   ) dut (
      .clk                        (clk),
      .reset                      (reset),
      .ex_valid                   (ex_valid),
      .ex_reg                     (ex_reg),
      .ex_value                   (ex_value),
      .ex_mask                    (ex_mask),
      .mem_valid                  (mem_valid),
      .mem_ready                  (mem_ready),
      .mem_reg                    (mem_reg),
      .mem_value                  (mem_value),
      .mem_mask                   (mem_mask),
      .wb_ex_stall                (wb_ex_stall),
      .fifo_count                 (fifo_count),
      .wb_writeback_reg           (wb_writeback_reg),
      .wb_writeback_value         (wb_writeback_value),
      .wb_writeback_mask          (wb_writeback_mask),
      .wb_enable_vector_writeback (wb_enable_vector_writeback)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_cnt [5];
      exp_cnt = '{3, 3, 2, 1, 0};
      reset = 1'b1;
      ex_valid = 1'b0; ex_reg = '0; ex_value = '0; ex_mask = '0;
      mem_valid = 1'b0; mem_reg = '0; mem_value = '0; mem_mask = '0;
      step();
      step();
      check("rst_en", 128'(wb_enable_vector_writeback), 128'(0));
      check("rst_reg", 128'(wb_writeback_reg), 128'(0));
      check("rst_cnt", 128'(fifo_count), 128'(0));
      check("rst_stall", 128'(wb_ex_stall), 128'(0));
      check("rst_ready", 128'(mem_ready), 128'(0));
      reset = 1'b0;
      #1;
      check("ready_after_rst", 128'(mem_ready), 128'(1));

      // 1: execute result
      ex_valid = 1'b1; ex_reg = 5'd3; ex_mask = 16'hFFFF;
      ex_value = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      step();
      ex_valid = 1'b0;
      check("t1_en", 128'(wb_enable_vector_writeback), 128'(1));
      check("t1_reg", 128'(wb_writeback_reg), 128'(3));
      check("t1_val", wb_writeback_value, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      check("t1_mask", 128'(wb_writeback_mask), 128'(16'hFFFF));
      check("t1_cnt", 128'(fifo_count), 128'(0));
      step();
      check("idle_en", 128'(wb_enable_vector_writeback), 128'(0));
      check("idle_hold", 128'(wb_writeback_reg), 128'(3));

      // 2: fall-through load
      mem_valid = 1'b1; mem_reg = 5'd7; mem_mask = 16'h00F0; mem_value = 128'hBEEF;
      step();
      mem_valid = 1'b0;
      check("t2_en", 128'(wb_enable_vector_writeback), 128'(1));
      check("t2_reg", 128'(wb_writeback_reg), 128'(7));
      check("t2_mask", 128'(wb_writeback_mask), 128'(16'h00F0));
      check("t2_val", wb_writeback_value, 128'hBEEF);
      check("t2_cnt", 128'(fifo_count), 128'(0));

      // 3: execute every cycle, 5 loads offered; 5th held while FIFO is full
      for (int i = 0; i < 9; i++) begin
         int k;
         k = (i < 4) ? i : 4;
         ex_valid = 1'b1; ex_reg = 5'd10; ex_mask = 16'h0F0F; ex_value = 128'(200 + i);
         mem_valid = 1'b1; mem_reg = 5'(16 + k); mem_value = 128'(160 + k);
         mem_mask = 16'(1 << k);
         #1;
         check("t3_ready", 128'(mem_ready), 128'((i < 4) ? 1 : 0));
         step();
         check("t3_val", wb_writeback_value, 128'(200 + i));
         check("t3_cnt", 128'(fifo_count), 128'((i < 4) ? i + 1 : 4));
         check("t3_stall", 128'(wb_ex_stall), 128'((i == 8) ? 1 : 0));
      end

      // 4: stall honoured, head issues, stall drops, loads drain in order
      ex_valid = 1'b0;
      for (int j = 0; j < 5; j++) begin
         #1;
         check("t4_ready", 128'(mem_ready), 128'((j == 0) ? 0 : 1));
         step();
         if (j == 1) mem_valid = 1'b0;
         check("t4_en", 128'(wb_enable_vector_writeback), 128'(1));
         check("t4_reg", 128'(wb_writeback_reg), 128'(16 + j));
         check("t4_val", wb_writeback_value, 128'(160 + j));
         check("t4_mask", 128'(wb_writeback_mask), 128'(1 << j));
         check("t4_cnt", 128'(fifo_count), 128'(exp_cnt[j]));
         check("t4_stall", 128'(wb_ex_stall), 128'(0));
      end
      step();
      check("t4_idle", 128'(wb_enable_vector_writeback), 128'(0));

      // 5: count=2 then simultaneous pop+push
      ex_valid = 1'b1; ex_value = 128'(500);
      mem_valid = 1'b1; mem_reg = 5'd20; mem_value = 128'(300); mem_mask = 16'h0003;
      step();
      mem_reg = 5'd21; mem_value = 128'(301); mem_mask = 16'h000C;
      step();
      check("t5_fill", 128'(fifo_count), 128'(2));
      ex_valid = 1'b0;
      mem_reg = 5'd22; mem_value = 128'(302); mem_mask = 16'h0000;
      step();
      mem_valid = 1'b0;
      check("t5_reg_a", 128'(wb_writeback_reg), 128'(20));
      check("t5_cnt", 128'(fifo_count), 128'(2));
      step();
      check("t5_reg_b", 128'(wb_writeback_reg), 128'(21));
      check("t5_val_b", wb_writeback_value, 128'(301));
      step();
      check("t5_reg_c", 128'(wb_writeback_reg), 128'(22));
      check("t5_zero_mask", 128'(wb_writeback_mask), 128'(0));
      check("t5_zero_en", 128'(wb_enable_vector_writeback), 128'(1));
      check("t5_empty", 128'(fifo_count), 128'(0));

      // 6: reset with count=3 and stall=1
      for (int i = 0; i < 9; i++) begin
         ex_valid = 1'b1; ex_value = 128'(400 + i);
         mem_valid = (i < 3); mem_reg = 5'(24 + i); mem_value = 128'(600 + i);
         step();
      end
      ex_valid = 1'b0; mem_valid = 1'b0;
      check("t6_cnt", 128'(fifo_count), 128'(3));
      check("t6_stall", 128'(wb_ex_stall), 128'(1));
      reset = 1'b1;
      step();
      check("t6_en", 128'(wb_enable_vector_writeback), 128'(0));
      check("t6_reg", 128'(wb_writeback_reg), 128'(0));
      check("t6_val", wb_writeback_value, 128'(0));
      check("t6_mask", 128'(wb_writeback_mask), 128'(0));
      check("t6_rcnt", 128'(fifo_count), 128'(0));
      check("t6_rstall", 128'(wb_ex_stall), 128'(0));
      check("t6_ready_rst", 128'(mem_ready), 128'(0));
      reset = 1'b0;
      #1;
      check("t6_ready", 128'(mem_ready), 128'(1));
      step();
      check("t6_idle", 128'(wb_enable_vector_writeback), 128'(0));
      check("t6_cnt_idle", 128'(fifo_count), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
